// File: rtl/rob_pkg.sv
// Shared types and id/slot helpers for the reorder buffer.
// Slot s carries rename id s+1; id 0 means "no producer".
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ID_W      = 5;
  localparam int SLOT_W    = $clog2(ROB_DEPTH);
  localparam int CNT_W     = SLOT_W + 1;
  localparam int RD_W      = 5;
  localparam int XLEN      = 32;

  localparam logic [ID_W-1:0] ID_NONE = '0;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic            mispred;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] target;
  } rob_entry_t;

  function automatic logic [SLOT_W-1:0] id_to_slot(input logic [ID_W-1:0] id);
    return SLOT_W'(id - ID_W'(1));
  endfunction

  function automatic logic [ID_W-1:0] slot_to_id(input logic [SLOT_W-1:0] slot);
    return ID_W'(slot) + ID_W'(1);
  endfunction

  function automatic logic id_in_range(input logic [ID_W-1:0] id);
    return (id != ID_NONE) && (id <= ID_W'(ROB_DEPTH));
  endfunction

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] slot);
    return (slot == SLOT_W'(ROB_DEPTH - 1)) ? '0 : slot + SLOT_W'(1);
  endfunction

endpackage

// File: rtl/rob_query.sv
// Operand lookup for one decode source: completed-but-uncommitted value by rename id.
// Same-cycle completion bus forwarding when ROB_CDB_FWD_EN is defined.
module rob_query
  import rob_pkg::*;
(
  input  logic            en,
  input  rob_entry_t      entries [ROB_DEPTH],
  input  logic [ID_W-1:0] id,
  input  logic            cdb_valid,
  input  logic [ID_W-1:0] cdb_id,
  input  logic [XLEN-1:0] cdb_data,
  output logic            rdy,
  output logic [XLEN-1:0] data
);

  rob_entry_t hit;
  logic       unused_hit;

  assign hit        = entries[id_to_slot(id)];
  assign unused_hit = ^{hit.pc, hit.target, hit.mispred, hit.rd};

`ifdef ROB_CDB_FWD_EN
  always_comb begin
    rdy  = 1'b0;
    data = '0;
    if (en && id_in_range(id) && hit.valid) begin
      if (cdb_valid && (cdb_id == id)) begin
        rdy  = 1'b1;
        data = cdb_data;
      end else if (hit.done) begin
        rdy  = 1'b1;
        data = hit.data;
      end
    end
  end
`else
  logic unused_cdb;
  assign unused_cdb = ^{cdb_valid, cdb_id, cdb_data};

  always_comb begin
    rdy  = 1'b0;
    data = '0;
    if (en && id_in_range(id) && hit.valid && hit.done) begin
      rdy  = 1'b1;
      data = hit.data;
    end
  end
`endif

endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates rename ids, collects completions, retires in order.
// Optional same-cycle operand forwarding from the completion bus: ROB_CDB_FWD_EN.
module rob
  import rob_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            alloc_req,
  input  logic [RD_W-1:0] alloc_rd,
  input  logic [XLEN-1:0] alloc_pc,
  output logic [ID_W-1:0] alloc_id,
  output logic            full,
  input  logic            cdb_valid,
  input  logic [ID_W-1:0] cdb_id,
  input  logic [XLEN-1:0] cdb_data,
  input  logic            cdb_mispred,
  input  logic [XLEN-1:0] cdb_target,
  input  logic [ID_W-1:0] q1_id,
  input  logic [ID_W-1:0] q2_id,
  output logic            q1_rdy,
  output logic            q2_rdy,
  output logic [XLEN-1:0] q1_data,
  output logic [XLEN-1:0] q2_data,
  output logic            we,
  output logic [RD_W-1:0] waddr,
  output logic [ID_W-1:0] wid,
  output logic [XLEN-1:0] wdata,
  output logic            rst_c,
  output logic [XLEN-1:0] flush_pc
);

  rob_entry_t        entry_reg [ROB_DEPTH];
  logic [SLOT_W-1:0] head_reg;
  logic [SLOT_W-1:0] tail_reg;
  logic [CNT_W-1:0]  count_reg;

  rob_entry_t        head_entry;
  logic              commit;
  logic              flush;
  logic              alloc_fire;
  logic              cdb_fire;
  logic [SLOT_W-1:0] cdb_slot;
  logic              unused_pc;

  assign head_entry = entry_reg[head_reg];
  assign unused_pc  = ^head_entry.pc;

  assign commit     = rst && rdy && head_entry.valid && head_entry.done;
  assign flush      = commit && head_entry.mispred;
  assign full       = rst && (count_reg == CNT_W'(ROB_DEPTH));
  assign alloc_fire = rst && rdy && alloc_req && !full && !flush;
  assign cdb_slot   = id_to_slot(cdb_id);
  assign cdb_fire   = rst && rdy && cdb_valid && id_in_range(cdb_id)
                      && entry_reg[cdb_slot].valid && !flush;

  assign alloc_id = slot_to_id(tail_reg);
  assign we       = commit && (head_entry.rd != '0);
  assign waddr    = head_entry.rd;
  assign wid      = slot_to_id(head_reg);
  assign wdata    = head_entry.data;
  assign rst_c    = flush;
  assign flush_pc = head_entry.target;

  // Alloc and completion never hit the same slot: alloc needs it empty, cdb needs it valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) entry_reg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) entry_reg[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (commit && (head_reg == SLOT_W'(i))) entry_reg[i].valid <= 1'b0;
        if (alloc_fire && (tail_reg == SLOT_W'(i))) begin
          entry_reg[i].valid   <= 1'b1;
          entry_reg[i].done    <= 1'b0;
          entry_reg[i].mispred <= 1'b0;
          entry_reg[i].rd      <= alloc_rd;
          entry_reg[i].pc      <= alloc_pc;
        end
        if (cdb_fire && (cdb_slot == SLOT_W'(i))) begin
          entry_reg[i].done    <= 1'b1;
          entry_reg[i].data    <= cdb_data;
          entry_reg[i].mispred <= cdb_mispred;
          entry_reg[i].target  <= cdb_target;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (commit)     head_reg <= slot_inc(head_reg);
      if (alloc_fire) tail_reg <= slot_inc(tail_reg);
      count_reg <= count_reg + CNT_W'(alloc_fire) - CNT_W'(commit);
    end
  end

  rob_query u_q1 (
    .en        (rst),
    .entries   (entry_reg),
    .id        (q1_id),
    .cdb_valid (cdb_valid),
    .cdb_id    (cdb_id),
    .cdb_data  (cdb_data),
    .rdy       (q1_rdy),
    .data      (q1_data)
  );

  rob_query u_q2 (
    .en        (rst),
    .entries   (entry_reg),
    .id        (q2_id),
    .cdb_valid (cdb_valid),
    .cdb_id    (cdb_id),
    .cdb_data  (cdb_data),
    .rdy       (q2_rdy),
    .data      (q2_data)
  );

endmodule
